// File: rtl/irda_fir_4ppm_demod.sv
// IrDA FIR 4PPM demodulator: hunts preamble, checks start/stop flags and
// assembles 4PPM dibits into bytes from the bit-synchronizer chip stream.
module irda_fir_4ppm_demod #(
   parameter int unsigned PRE_MIN   = 4,
   parameter int unsigned MAX_BYTES = 2050
) (
   input  logic       clk,
   input  logic       wb_rst_i,
   input  logic       bs_restart,
   input  logic       chip_i,
   input  logic       chip_stb,
   output logic [7:0] data_o,
   output logic       data_valid_o,
   output logic       frame_start_o,
   output logic       frame_end_o,
   output logic       frame_err_o,
   output logic       resync_o
);

   localparam int unsigned WIN_W  = 32;
   localparam int unsigned CHIP_W = 5;
   localparam int unsigned PRE_W  = 8;
   localparam int unsigned BYTE_W = $clog2(MAX_BYTES + 1);

   localparam logic [15:0]       PRE_PAT   = 16'h80A8;
   localparam logic [WIN_W-1:0]  START_PAT = 32'h0C0C_6060;
   localparam logic [WIN_W-1:0]  STOP_PAT  = 32'h0C0C_0606;
   localparam logic [PRE_W-1:0]  PRE_MIN_L = PRE_W'(PRE_MIN);
   localparam logic [BYTE_W-1:0] MAX_B_L   = BYTE_W'(MAX_BYTES);
   localparam logic [CHIP_W-1:0] LAST16    = CHIP_W'(15);
   localparam logic [CHIP_W-1:0] LAST28    = CHIP_W'(27);

   localparam logic [2:0] HUNT     = 3'd0;
   localparam logic [2:0] PREAMBLE = 3'd1;
   localparam logic [2:0] START    = 3'd2;
   localparam logic [2:0] DATA     = 3'd3;
   localparam logic [2:0] STOP     = 3'd4;

   logic [2:0]        state, state_nx;
   logic [WIN_W-1:0]  win, win_nx, win_sh;
   logic [CHIP_W-1:0] chip_cnt, chip_cnt_nx;
   logic [PRE_W-1:0]  pre_cnt, pre_cnt_nx;
   logic [1:0]        dibit_cnt, dibit_cnt_nx;
   logic [BYTE_W-1:0] byte_cnt, byte_cnt_nx;
   logic [5:0]        part, part_nx;
   logic [7:0]        data_nx;
   logic              valid_nx, start_nx, end_nx, err_nx, resync_nx;
   logic              sym_ok;
   logic [1:0]        dib;

   // State and datapath registers
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state         <= HUNT;
         win           <= '0;
         chip_cnt      <= '0;
         pre_cnt       <= '0;
         dibit_cnt     <= '0;
         byte_cnt      <= '0;
         part          <= '0;
         data_o        <= 8'h00;
         data_valid_o  <= 1'b0;
         frame_start_o <= 1'b0;
         frame_end_o   <= 1'b0;
         frame_err_o   <= 1'b0;
         resync_o      <= 1'b0;
      end else begin
         state         <= state_nx;
         win           <= win_nx;
         chip_cnt      <= chip_cnt_nx;
         pre_cnt       <= pre_cnt_nx;
         dibit_cnt     <= dibit_cnt_nx;
         byte_cnt      <= byte_cnt_nx;
         part          <= part_nx;
         data_o        <= data_nx;
         data_valid_o  <= valid_nx;
         frame_start_o <= start_nx;
         frame_end_o   <= end_nx;
         frame_err_o   <= err_nx;
         resync_o      <= resync_nx;
      end
   end

   // Next-state, window/counter update and output pulse decode
   always_comb begin
      state_nx     = state;
      win_nx       = win;
      chip_cnt_nx  = chip_cnt;
      pre_cnt_nx   = pre_cnt;
      dibit_cnt_nx = dibit_cnt;
      byte_cnt_nx  = byte_cnt;
      part_nx      = part;
      data_nx      = data_o;
      valid_nx     = 1'b0;
      start_nx     = 1'b0;
      end_nx       = 1'b0;
      err_nx       = 1'b0;
      resync_nx    = 1'b0;
      win_sh       = {win[WIN_W-2:0], chip_i};
      sym_ok       = 1'b1;
      dib          = 2'd0;

      case (win_sh[3:0])
         4'b1000: dib = 2'd0;
         4'b0100: dib = 2'd1;
         4'b0010: dib = 2'd2;
         4'b0001: dib = 2'd3;
         default: sym_ok = 1'b0;
      endcase

      if (bs_restart) begin
         state_nx     = HUNT;
         win_nx       = '0;
         chip_cnt_nx  = '0;
         pre_cnt_nx   = '0;
         dibit_cnt_nx = '0;
         byte_cnt_nx  = '0;
         part_nx      = '0;
      end else if (chip_stb) begin
         win_nx      = win_sh;
         chip_cnt_nx = chip_cnt + CHIP_W'(1);
         case (state)
            HUNT: begin
               if (win_sh[15:0] == PRE_PAT) begin
                  state_nx    = PREAMBLE;
                  pre_cnt_nx  = PRE_W'(1);
                  chip_cnt_nx = '0;
               end
            end
            PREAMBLE: begin
               if (chip_cnt == LAST16) begin
                  chip_cnt_nx = '0;
                  if (win_sh[15:0] == PRE_PAT) begin
                     if (pre_cnt != '1) pre_cnt_nx = pre_cnt + PRE_W'(1);
                  end else if (pre_cnt >= PRE_MIN_L) begin
                     state_nx = START;
                  end else begin
                     state_nx = HUNT;
                  end
               end
            end
            START: begin
               if (chip_cnt == LAST16) begin
                  chip_cnt_nx = '0;
                  if (win_sh == START_PAT) begin
                     state_nx     = DATA;
                     start_nx     = 1'b1;
                     dibit_cnt_nx = '0;
                     byte_cnt_nx  = '0;
                     part_nx      = '0;
                  end else begin
                     state_nx = HUNT;
                  end
               end
            end
            DATA: begin
               if (chip_cnt[1:0] == 2'd3) begin
                  chip_cnt_nx = '0;
                  if (sym_ok) begin
                     dibit_cnt_nx = dibit_cnt + 2'(1);
                     part_nx      = {dib, part[5:2]};
                     if (dibit_cnt == 2'd3) begin
                        // A byte beyond the limit is an overrun, not data
                        if (byte_cnt == MAX_B_L) begin
                           err_nx    = 1'b1;
                           resync_nx = 1'b1;
                           state_nx  = HUNT;
                        end else begin
                           data_nx     = {dib, part};
                           valid_nx    = 1'b1;
                           byte_cnt_nx = byte_cnt + BYTE_W'(1);
                        end
                     end
                  end else if (win_sh[3:0] == 4'b0000 && dibit_cnt == 2'd0) begin
                     state_nx = STOP;
                  end else begin
                     err_nx    = 1'b1;
                     resync_nx = 1'b1;
                     state_nx  = HUNT;
                  end
               end
            end
            STOP: begin
               if (chip_cnt == LAST28) begin
                  chip_cnt_nx = '0;
                  state_nx    = HUNT;
                  resync_nx   = 1'b1;
                  if (win_sh == STOP_PAT) end_nx = 1'b1;
                  else                    err_nx = 1'b1;
               end
            end
            default: begin
               state_nx    = HUNT;
               chip_cnt_nx = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irda_fir_4ppm_demod.sv
// Scoreboard bench: directed frames push expected events, a negedge monitor
// pops and compares each output pulse the demodulator produces.
module tb_irda_fir_4ppm_demod;

   localparam int unsigned MAXB = 3;
   localparam logic [2:0] EV_NONE = 3'd0, EV_START = 3'd1, EV_DATA = 3'd2,
                          EV_END = 3'd3, EV_ERR = 3'd4;

   logic       clk = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic       bs_restart = 1'b0;
   logic       chip_i = 1'b0;
   logic       chip_stb = 1'b0;
   logic [7:0] data_o;
   logic       data_valid_o, frame_start_o, frame_end_o, frame_err_o, resync_o;

   int checks = 0;
   int errors = 0;
   int gap_max = 1;
   logic [10:0] exp_q[$];

   irda_fir_4ppm_demod #(.PRE_MIN(4), .MAX_BYTES(MAXB)) dut (
      .clk(clk), .wb_rst_i(wb_rst_i), .bs_restart(bs_restart),
      .chip_i(chip_i), .chip_stb(chip_stb), .data_o(data_o),
      .data_valid_o(data_valid_o), .frame_start_o(frame_start_o),
      .frame_end_o(frame_end_o), .frame_err_o(frame_err_o), .resync_o(resync_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [2:0] k, input logic [7:0] d);
      exp_q.push_back({k, d});
   endtask

   // Monitor: every pulse must match the head of the expectation queue
   always @(negedge clk) begin : mon
      int n;
      logic [10:0] got;
      if (!wb_rst_i) begin
         n = $countones({data_valid_o, frame_start_o, frame_end_o, frame_err_o});
         if (n > 1) check("one_pulse", 32'(n), 32'd1);
         if (n > 0 || resync_o) begin
            check("resync", 32'(resync_o), 32'(frame_end_o | frame_err_o));
            if (frame_start_o)     got = {EV_START, 8'h00};
            else if (data_valid_o) got = {EV_DATA, data_o};
            else if (frame_end_o)  got = {EV_END, 8'h00};
            else if (frame_err_o)  got = {EV_ERR, 8'h00};
            else                   got = {EV_NONE, 8'h00};
            if (exp_q.size() == 0) check("unexpected_event", 32'(got), 32'h7FF);
            else                   check("event", 32'(got), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic chip(input logic b);
      int g;
      chip_i = b;
      chip_stb = 1'b1;
      @(posedge clk); #1;
      chip_stb = 1'b0;
      chip_i = 1'b0;
      g = (gap_max > 1) ? int'($urandom_range(gap_max, 1)) : 1;
      repeat (g - 1) begin @(posedge clk); #1; end
   endtask

   task automatic bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) chip(v[i]);
   endtask

   task automatic sym(input logic [1:0] d);
      logic [3:0] s;
      s = 4'b1000 >> d;
      bits(32'(s), 4);
   endtask

   task automatic byte_t(input logic [7:0] b);
      for (int i = 0; i < 4; i++) sym(b[2*i +: 2]);
   endtask

   task automatic preambles(input int n);
      repeat (n) bits(32'h0000_80A8, 16);
   endtask

   task automatic good_frame(input int npre, input int nb, input logic [7:0] b0);
      push(EV_START, 8'h00);
      for (int i = 0; i < nb; i++) push(EV_DATA, b0 + 8'(i * 37));
      push(EV_END, 8'h00);
      preambles(npre);
      bits(32'h0C0C_6060, 32);
      for (int i = 0; i < nb; i++) byte_t(b0 + 8'(i * 37));
      bits(32'h0C0C_0606, 32);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_idle(input string name);
      check({name, "_data"}, 32'(data_o), 32'h0);
      check({name, "_pulses"},
            32'({data_valid_o, frame_start_o, frame_end_o, frame_err_o, resync_o}), 32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1;
      wb_rst_i = 1'b0;

      // Basic frame, byte 0x39
      good_frame(16, 1, 8'h39);
      drain("drain_basic");

      // Too few preambles, then exactly PRE_MIN preambles decode
      preambles(3);
      bits(32'h0C0C_6060, 32);
      good_frame(4, 2, 8'hA5);
      drain("drain_premin");

      // Illegal multi-one symbol, then a clean frame
      push(EV_START, 8'h00);
      push(EV_ERR, 8'h00);
      preambles(8);
      bits(32'h0C0C_6060, 32);
      bits(32'hC, 4);
      good_frame(5, 1, 8'h5C);
      drain("drain_badsym");

      // Mid-byte 0000 symbol
      push(EV_START, 8'h00);
      push(EV_ERR, 8'h00);
      preambles(4);
      bits(32'h0C0C_6060, 32);
      sym(2'd1);
      sym(2'd2);
      bits(32'h0, 4);
      drain("drain_midstop");

      // Corrupted stop flag
      push(EV_START, 8'h00);
      push(EV_DATA, 8'hC3);
      push(EV_ERR, 8'h00);
      preambles(4);
      bits(32'h0C0C_6060, 32);
      byte_t(8'hC3);
      bits(32'h0C0C_0607, 32);
      drain("drain_badstop");

      // Exactly MAX_BYTES bytes, then overrun on byte MAX_BYTES+1
      good_frame(4, MAXB, 8'h11);
      push(EV_START, 8'h00);
      for (int i = 0; i < MAXB; i++) push(EV_DATA, 8'h20 + 8'(i));
      push(EV_ERR, 8'h00);
      preambles(4);
      bits(32'h0C0C_6060, 32);
      for (int i = 0; i <= MAXB; i++) byte_t(8'h20 + 8'(i));
      drain("drain_overrun");

      // bs_restart with a chip strobe mid-DATA
      push(EV_START, 8'h00);
      push(EV_DATA, 8'h27);
      preambles(4);
      bits(32'h0C0C_6060, 32);
      byte_t(8'h27);
      sym(2'd1);
      chip_i = 1'b1;
      chip_stb = 1'b1;
      bs_restart = 1'b1;
      @(posedge clk); #1;
      chip_stb = 1'b0;
      bs_restart = 1'b0;
      @(negedge clk);
      check("restart_quiet",
            32'({data_valid_o, frame_start_o, frame_end_o, frame_err_o, resync_o}), 32'h0);
      check("restart_data_hold", 32'(data_o), 32'h27);
      @(posedge clk); #1;
      sym(2'd2);
      sym(2'd3);
      bits(32'h0C0C_0606, 32);
      good_frame(4, 1, 8'h9E);
      drain("drain_restart");

      // Reset during STOP aborts silently
      push(EV_START, 8'h00);
      push(EV_DATA, 8'h4B);
      preambles(4);
      bits(32'h0C0C_6060, 32);
      byte_t(8'h4B);
      bits(32'h0C0C, 16);
      drain("drain_prereset");
      wb_rst_i = 1'b1;
      @(negedge clk);
      check_idle("midreset");
      @(posedge clk); #1;
      wb_rst_i = 1'b0;
      bits(32'h0606, 16);
      good_frame(4, 1, 8'hD2);
      drain("drain_postreset");

      // Basic frame with random strobe spacing
      gap_max = 12;
      good_frame(16, 1, 8'h39);
      gap_max = 1;
      drain("drain_random");

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
